rst_seq_ctrl: RTL and testbench
===============================

Name: rst_seq_ctrl

Overview:
- Parametrised clock-domain reset sequencer for the miniCPU platform.
- Synchronises deassertion of the board reset and holds all resets for a programmable interval.
- Then releases NUM_CH active-low reset channels in a fixed staggered order: core, peripherals, ...
- Supports a synchronous software-reset request and reports the last reset cause.
- Sits between the board reset/clock source and miniCPU plus its peripherals; replaces the fixed hold-off reset used in simulation.

Parameters:
- NUM_CH, 2: number of reset output channels (>=1).
- SYNC_STAGES, 2: reset-deassertion synchroniser depth (>=2).
- HOLD_CYCLES, 250: cycles all channels stay asserted after synchronised deassertion (>=1).
- STAGGER, 4: cycles between successive channel releases (>=1).
- WDT_CYCLES, 1024: watchdog timeout in cycles. Used only with RST_SEQ_WDT_EN.

Ports:
- clk_i, input, 1: system clock.
- rst_i, input, 1: asynchronous, active-high reset.
- sw_rst_i, input, 1: synchronous software reset request, sampled per cycle.
- wdt_kick_i, input, 1: watchdog kick. Ignored unless RST_SEQ_WDT_EN.
- rst_n_o, output, NUM_CH: active-low channel resets. Bit 0 is released first.
- ready_o, output, 1: high once all channels are released.
- cause_o, output, 2: last reset cause. 0 = external, 1 = software, 2 = watchdog.
- state_o, output, 2: FSM state. 0 = SYNC, 1 = HOLD, 2 = REL, 3 = RUN.

Behaviour:
- rst_i high (async, any time, including mid-sequence):
  - synchroniser cleared to 0; FSM = SYNC; counters = 0.
  - rst_n_o = all 0, ready_o = 0, cause_o = 0, state_o = 0.
- Synchroniser:
  - SYNC_STAGES-bit shift chain, shifts in 1 each edge while rst_i low.
  - sync_ok = last stage.
  - Edge E0 = the SYNC_STAGES-th rising edge after rst_i falls.
- SYNC: on the edge where sync_ok becomes 1 (E0), go to HOLD with counter = 0. sw_rst_i is ignored in SYNC.
- HOLD: counter increments each cycle. After HOLD_CYCLES cycles, go to REL; rst_n_o[0] rises at edge E0+HOLD_CYCLES.
- REL:
  - rst_n_o[i] rises at edge E0+HOLD_CYCLES+i*STAGGER; released bits stay 1.
  - On the edge releasing bit NUM_CH-1, go to RUN and ready_o rises at that same edge.
  - NUM_CH=1: go directly HOLD->RUN at E0+HOLD_CYCLES.
- RUN: outputs stable until a reset event.
- Software reset (sw_rst_i=1 sampled at edge T, state HOLD/REL/RUN):
  - At T: rst_n_o = 0, ready_o = 0, cause_o = 1, FSM = HOLD, counters = 0. Synchroniser untouched.
  - Sequence repeats with T in place of E0.
- sw_rst_i held high: HOLD restarts every cycle; release starts HOLD_CYCLES cycles after the last sampled 1.
- Counter widths: $clog2 of the largest count + 1. No wrap is possible within legal parameters.
- cause_o changes only on a reset event and persists through the sequence.
- All outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro: RST_SEQ_WDT_EN.
- Defined:
  - A watchdog counter runs only in RUN and clears on wdt_kick_i=1 or on leaving RUN.
  - When it reaches WDT_CYCLES-1 with no kick that cycle, the next edge acts as a software reset with cause_o = 2.
  - Kick and timeout in the same cycle: kick wins, no reset.
  - sw_rst_i and timeout in the same cycle: software reset, cause_o = 1.
- Undefined:
  - No watchdog logic; wdt_kick_i is unused.
  - cause_o never equals 2. WDT_CYCLES has no effect.

Test Plan:
- Defaults, rst_i high 10 cycles then low at edge 0:
  - rst_n_o = 2'b00, ready_o = 0 through edge 251.
  - rst_n_o = 2'b01 at edge 252.
  - rst_n_o = 2'b11 and ready_o = 1 at edge 256.
  - state_o goes 0 -> 1 at edge 2, 2 at 252, 3 at 256.
- In RUN, one-cycle sw_rst_i pulse sampled at edge T:
  - at T: rst_n_o = 00, ready_o = 0, cause_o = 1, state_o = 1.
  - rst_n_o = 01 at T+250; rst_n_o = 11 and ready_o = 1 at T+254.
- Reset mid-sequence:
  - rst_i pulsed asynchronously (between edges) at edge 253 while rst_n_o = 01: rst_n_o = 00 immediately, cause_o = 0.
  - Full sequence restarts: rst_n_o = 01 at 252 edges after the rst_i fall.
- sw_rst_i held high 20 cycles during HOLD: no release until 250 edges after the last sampled 1; sw_rst_i pulsed in SYNC is ignored.
- NUM_CH=3, STAGGER=1, HOLD_CYCLES=5: rst_n_o goes 001 at edge 7, 011 at edge 8, 111 at edge 9 with ready_o = 1 at edge 9.
- RST_SEQ_WDT_EN, WDT_CYCLES=16, no kicks in RUN: reset at the 16th RUN cycle with cause_o = 2. Kicking every 10 cycles gives no reset for 200 cycles.

Source files
------------

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: synchronises board-reset deassertion, holds, then releases channels in a staggered order.
// Optional watchdog auto-reset is compiled in with `define RST_SEQ_WDT_EN.
module rst_seq_ctrl #(
    parameter int NUM_CH      = 2,
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 250,
    parameter int STAGGER     = 4,
    parameter int WDT_CYCLES  = 1024
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              sw_rst_i,
    input  logic              wdt_kick_i,
    output logic [NUM_CH-1:0] rst_n_o,
    output logic              ready_o,
    output logic [1:0]        cause_o,
    output logic [1:0]        state_o
);
    typedef enum logic [1:0] {ST_SYNC = 2'd0, ST_HOLD = 2'd1, ST_REL = 2'd2, ST_RUN = 2'd3} state_t;
    typedef enum logic [1:0] {CAUSE_EXT = 2'd0, CAUSE_SW = 2'd1, CAUSE_WDT = 2'd2} cause_t;

    localparam int MAX_SEQ = (HOLD_CYCLES > STAGGER) ? HOLD_CYCLES : STAGGER;
`ifdef RST_SEQ_WDT_EN
    localparam int MAX_CNT = (MAX_SEQ > WDT_CYCLES) ? MAX_SEQ : WDT_CYCLES;
`else
    localparam int MAX_CNT = MAX_SEQ;
    localparam int WDT_CYCLES_UNUSED = WDT_CYCLES;
`endif
    localparam int CNT_W = $clog2(MAX_CNT) + 1;
    localparam int CH_W  = $clog2(NUM_CH + 1);

    logic [SYNC_STAGES-1:0] r_sync;
    state_t                 r_state, w_state_nxt;
    logic [CNT_W-1:0]       r_cnt, w_cnt_nxt;
    logic [CH_W-1:0]        r_ch, w_ch_nxt;
    logic [NUM_CH-1:0]      r_rst_n, w_rst_n_nxt;
    logic                   r_ready, w_ready_nxt;
    cause_t                 r_cause, w_cause_nxt;
    logic                   w_sync_rise;
    logic                   w_sw_evt;
    logic                   w_wdt_evt;
    logic                   w_restart;
    logic                   w_rel;

    // Fires on the single edge where the last synchroniser stage turns to 1.
    assign w_sync_rise = r_sync[SYNC_STAGES-2] & ~r_sync[SYNC_STAGES-1];
    assign w_sw_evt    = sw_rst_i && (r_state != ST_SYNC);

`ifdef RST_SEQ_WDT_EN
    logic [CNT_W-1:0] r_wdt, w_wdt_nxt;

    // A kick in the timeout cycle wins; a software request takes priority for the cause.
    assign w_wdt_evt = (r_state == ST_RUN) && !wdt_kick_i && (r_wdt == CNT_W'(WDT_CYCLES - 1));
    assign w_wdt_nxt = ((r_state == ST_RUN) && !wdt_kick_i && !w_restart) ? r_wdt + CNT_W'(1) : '0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_wdt <= '0;
        else       r_wdt <= w_wdt_nxt;
    end
`else
    logic w_unused_kick;

    assign w_wdt_evt     = 1'b0;
    assign w_unused_kick = wdt_kick_i;
`endif

    assign w_restart = w_sw_evt | w_wdt_evt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst_i) begin
            r_sync  <= '0;
            r_state <= ST_SYNC;
            r_cnt   <= '0;
            r_ch    <= '0;
            r_rst_n <= '0;
            r_ready <= 1'b0;
            r_cause <= CAUSE_EXT;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], 1'b1};
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ch    <= w_ch_nxt;
            r_rst_n <= w_rst_n_nxt;
            r_ready <= w_ready_nxt;
            r_cause <= w_cause_nxt;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + CNT_W'(1);
        w_ch_nxt    = r_ch;
        w_rel       = 1'b0;
        if (w_restart) begin
            w_state_nxt = ST_HOLD;
            w_cnt_nxt   = '0;
            w_ch_nxt    = '0;
        end else begin
            case (r_state)
                ST_SYNC: begin
                    w_cnt_nxt = '0;
                    if (w_sync_rise) w_state_nxt = ST_HOLD;
                end
                ST_HOLD: begin
                    if (r_cnt == CNT_W'(HOLD_CYCLES - 1)) begin
                        w_rel       = 1'b1;
                        w_cnt_nxt   = '0;
                        w_ch_nxt    = r_ch + CH_W'(1);
                        w_state_nxt = (NUM_CH == 1) ? ST_RUN : ST_REL;
                    end
                end
                ST_REL: begin
                    if (r_cnt == CNT_W'(STAGGER - 1)) begin
                        w_rel     = 1'b1;
                        w_cnt_nxt = '0;
                        w_ch_nxt  = r_ch + CH_W'(1);
                        if (r_ch == CH_W'(NUM_CH - 1)) w_state_nxt = ST_RUN;
                    end
                end
                default: w_cnt_nxt = r_cnt;
            endcase
        end
    end

    always_comb begin
        w_rst_n_nxt = r_rst_n;
        w_ready_nxt = r_ready;
        w_cause_nxt = r_cause;
        if (w_restart) begin
            w_rst_n_nxt = '0;
            w_ready_nxt = 1'b0;
            w_cause_nxt = w_sw_evt ? CAUSE_SW : CAUSE_WDT;
        end else if (w_rel) begin
            w_rst_n_nxt = r_rst_n | (NUM_CH'(1) << r_ch);
            w_ready_nxt = (w_state_nxt == ST_RUN);
        end
    end

    assign rst_n_o = r_rst_n;
    assign ready_o = r_ready;
    assign cause_o = r_cause;
    assign state_o = r_state;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Self-checking bench for rst_seq_ctrl: two parameter sets driven together against a timeline model.
// Watchdog scenarios are included when RST_SEQ_WDT_EN is defined.
module tb_rst_seq_ctrl;
    localparam int NI   = 2;
    localparam int SYNC = 2;
    localparam int P_N [NI] = '{2, 3};
    localparam int P_H [NI] = '{250, 5};
    localparam int P_S [NI] = '{4, 1};
    localparam int P_W [NI] = '{1024, 16};
`ifdef RST_SEQ_WDT_EN
    localparam bit WDT_ON = 1'b1;
`else
    localparam bit WDT_ON = 1'b0;
`endif

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic       sw_rst_i = 1'b0;
    logic       wdt_kick_i = 1'b0;
    logic [1:0] rst_n_0;
    logic [2:0] rst_n_1;
    logic       ready_0, ready_1;
    logic [1:0] cause_0, cause_1, state_0, state_1;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Model: sequence anchor (E0 or software/watchdog restart edge) plus elapsed-time arithmetic.
    bit m_done  [NI];
    int m_scnt  [NI];
    int m_anchor[NI];
    int m_cause [NI];
    int m_kick  [NI];

    always #5 clk_i = ~clk_i;

    rst_seq_ctrl u_dut0 (
        .clk_i(clk_i), .rst_i(rst_i), .sw_rst_i(sw_rst_i), .wdt_kick_i(wdt_kick_i),
        .rst_n_o(rst_n_0), .ready_o(ready_0), .cause_o(cause_0), .state_o(state_0)
    );

    rst_seq_ctrl #(.NUM_CH(3), .SYNC_STAGES(2), .HOLD_CYCLES(5), .STAGGER(1), .WDT_CYCLES(16)) u_dut1 (
        .clk_i(clk_i), .rst_i(rst_i), .sw_rst_i(sw_rst_i), .wdt_kick_i(wdt_kick_i),
        .rst_n_o(rst_n_1), .ready_o(ready_1), .cause_o(cause_1), .state_o(state_1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at edge %0d: got %0h, expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic int rel_cnt(input int k, input int t);
        int e, r;
        if (!m_done[k]) return 0;
        e = t - m_anchor[k];
        if (e < P_H[k]) return 0;
        r = (e - P_H[k]) / P_S[k] + 1;
        return (r > P_N[k]) ? P_N[k] : r;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NI; k++) begin
            m_done[k]  = 1'b0;
            m_scnt[k]  = 0;
            m_cause[k] = 0;
        end
    endtask

    task automatic model_edge();
        int t, ref_t, run_at;
        bit pre_run;
        t = cyc + 1;
        for (int k = 0; k < NI; k++) begin
            pre_run = m_done[k] && (rel_cnt(k, cyc) == P_N[k]);
            run_at  = m_anchor[k] + P_H[k] + (P_N[k] - 1) * P_S[k];
            ref_t   = (m_kick[k] > run_at) ? m_kick[k] : run_at;
            if (rst_i) begin
                m_done[k] = 1'b0;
                m_scnt[k] = 0;
                m_cause[k] = 0;
            end else if (!m_done[k]) begin
                m_scnt[k]++;
                if (m_scnt[k] == SYNC) begin
                    m_done[k]   = 1'b1;
                    m_anchor[k] = t;
                end
            end else if (sw_rst_i) begin
                m_anchor[k] = t;
                m_cause[k]  = 1;
            end else if (pre_run) begin
                if (wdt_kick_i) m_kick[k] = t;
                else if (WDT_ON && (t - ref_t >= P_W[k])) begin
                    m_anchor[k] = t;
                    m_cause[k]  = 2;
                end
            end
        end
        cyc = t;
    endtask

    task automatic check_all();
        int r, es;
        logic [31:0] o_rstn, o_rdy, o_cause, o_state;
        for (int k = 0; k < NI; k++) begin
            r  = rel_cnt(k, cyc);
            es = !m_done[k] ? 0 : (r == 0) ? 1 : (r < P_N[k]) ? 2 : 3;
            o_rstn  = (k == 0) ? 32'(rst_n_0) : 32'(rst_n_1);
            o_rdy   = (k == 0) ? 32'(ready_0) : 32'(ready_1);
            o_cause = (k == 0) ? 32'(cause_0) : 32'(cause_1);
            o_state = (k == 0) ? 32'(state_0) : 32'(state_1);
            check($sformatf("u%0d.rst_n", k), o_rstn, (32'd1 << r) - 32'd1);
            check($sformatf("u%0d.ready", k), o_rdy, 32'(r == P_N[k]));
            check($sformatf("u%0d.cause", k), o_cause, 32'(m_cause[k]));
            check($sformatf("u%0d.state", k), o_state, 32'(es));
        end
    endtask

    task automatic step(input bit sw, input bit kick);
        sw_rst_i   = sw;
        wdt_kick_i = kick;
        @(posedge clk_i);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic run_to(input int t);
        while (cyc < t) step(1'b0, 1'b0);
    endtask

    task automatic rst_pulse_async(input int hold);
        #1;
        rst_i = 1'b1;
        model_reset();
        #1;
        check_all();
        check("async_rst_n0", 32'(rst_n_0), 32'd0);
        check("async_cause0", 32'(cause_0), 32'd0);
        repeat (hold) step(1'b0, 1'b0);
        rst_i = 1'b0;
    endtask

    initial begin
        int t0, tt, f, last, u, k_last;
        for (int k = 0; k < NI; k++) begin
            m_anchor[k] = 0;
            m_kick[k]   = 0;
        end
        model_reset();
        #1 rst_i = 1'b1;
        repeat (10) step(1'b0, 1'b0);
        check("reset_rst_n0", 32'(rst_n_0), 32'd0);
        rst_i = 1'b0;
        t0 = cyc;

        // Power-on sequence with default and small parameter sets.
        run_to(t0 + 1);   check("e1_state0", 32'(state_0), 32'd0);
        run_to(t0 + 2);   check("e2_state0", 32'(state_0), 32'd1);
        run_to(t0 + 7);   check("e7_rst_n1", 32'(rst_n_1), 32'b001);
        run_to(t0 + 8);   check("e8_rst_n1", 32'(rst_n_1), 32'b011);
        run_to(t0 + 9);   check("e9_rst_n1", 32'(rst_n_1), 32'b111);
                          check("e9_ready1", 32'(ready_1), 32'd1);
        run_to(t0 + 251); check("e251_rst_n0", 32'(rst_n_0), 32'b00);
                          check("e251_ready0", 32'(ready_0), 32'd0);
        run_to(t0 + 252); check("e252_rst_n0", 32'(rst_n_0), 32'b01);
                          check("e252_state0", 32'(state_0), 32'd2);
        run_to(t0 + 256); check("e256_rst_n0", 32'(rst_n_0), 32'b11);
                          check("e256_ready0", 32'(ready_0), 32'd1);
                          check("e256_state0", 32'(state_0), 32'd3);

        // One-cycle software reset in RUN.
        run_to(t0 + 270);
        step(1'b1, 1'b0);
        tt = cyc;
        check("swT_rst_n0", 32'(rst_n_0), 32'd0);
        check("swT_cause0", 32'(cause_0), 32'd1);
        check("swT_state0", 32'(state_0), 32'd1);
        run_to(tt + 249); check("sw249_rst_n0", 32'(rst_n_0), 32'b00);
        run_to(tt + 250); check("sw250_rst_n0", 32'(rst_n_0), 32'b01);
        run_to(tt + 254); check("sw254_rst_n0", 32'(rst_n_0), 32'b11);
                          check("sw254_ready0", 32'(ready_0), 32'd1);

        // Asynchronous reset in the middle of the release phase.
        run_to(tt + 300);
        step(1'b1, 1'b0);
        tt = cyc;
        run_to(tt + 253);
        check("mid_rst_n0_pre", 32'(rst_n_0), 32'b01);
        rst_pulse_async(3);
        f = cyc;
        run_to(f + 251); check("mid251_rst_n0", 32'(rst_n_0), 32'b00);
        run_to(f + 252); check("mid252_rst_n0", 32'(rst_n_0), 32'b01);

        // Software reset during SYNC is ignored; held request keeps restarting HOLD.
        rst_pulse_async(2);
        f = cyc;
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        check("sync_sw_state0", 32'(state_0), 32'd1);
        check("sync_sw_cause0", 32'(cause_0), 32'd0);
        run_to(f + 30);
        repeat (20) step(1'b1, 1'b0);
        last = cyc;
        run_to(last + 249); check("held249_rst_n0", 32'(rst_n_0), 32'b00);
                            check("held249_state0", 32'(state_0), 32'd1);
        run_to(last + 250); check("held250_rst_n0", 32'(rst_n_0), 32'b01);
        run_to(last + 260);

`ifdef RST_SEQ_WDT_EN
        // Regular kicks keep the small instance running; then it times out.
        step(1'b1, 1'b0);
        u = cyc;
        k_last = u;
        for (int i = 0; i < 200; i++) begin
            step(1'b0, (i % 10) == 0);
            if ((i % 10) == 0) k_last = cyc;
        end
        check("kick_state1", 32'(state_1), 32'd3);
        check("kick_cause1", 32'(cause_1), 32'd1);
        run_to(k_last + 15); check("wdt15_state1", 32'(state_1), 32'd3);
        run_to(k_last + 16); check("wdt16_cause1", 32'(cause_1), 32'd2);
                             check("wdt16_state1", 32'(state_1), 32'd1);
                             check("wdt16_rst_n1", 32'(rst_n_1), 32'd0);
`else
        u = 0;
        k_last = 0;
`endif

        // Randomised traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                rst_pulse_async(int'($urandom_range(0, 3)));
            end else begin
                step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 8);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not finish, errors=%0d", n_errors);
        $fatal(1);
    end

endmodule
